// File: rtl/stack_pop_reader_if.sv
// Handshake bundle between the LIFO pop reader, the stack pop port,
// the command source and the downstream word consumer.
interface stack_pop_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_count;
    logic              stk_pop;
    logic              stk_push;
    logic              stk_full;
    logic              stk_empty;
    logic [DATA_W-1:0] stk_d_out;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              done;
    logic [CNT_W-1:0]  done_count;
    logic              done_short;

    modport master (
        input  cmd_valid, cmd_count, stk_push, stk_full, stk_empty, stk_d_out, m_ready,
        output cmd_ready, stk_pop, m_valid, m_data, done, done_count, done_short
    );

    modport slave (
        output cmd_valid, cmd_count, stk_push, stk_full, stk_empty, stk_d_out, m_ready,
        input  cmd_ready, stk_pop, m_valid, m_data, done, done_count, done_short
    );
endinterface

// File: rtl/stack_pop_reader.sv
// Read-side master for the LIFO stack: drains words on command and streams
// them out through a 2-entry buffer with in-flight credit tracking.
module stack_pop_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = ADDR_W + 1
) (
    input logic                 clk,
    input logic                 rst_n,
    stack_pop_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t            state;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  popped;
    logic              drain_mode;
    logic              short_flag;
    logic              inflight;
    logic [1:0]        occ;
    logic [DATA_W-1:0] fifo_mem [2];

    logic       deq;
    logic       push_wins;
    logic       have_work;
    logic [2:0] space_used;
    logic       pop_eligible;
    logic       pop_acc;

    // The stack silently drops a pop that collides with a successful push,
    // so only pops that survive that rule are counted or expected back.
    always_comb begin
        deq          = bus.m_valid & bus.m_ready;
        push_wins    = bus.stk_push & ~bus.stk_full;
        have_work    = drain_mode | (remaining != '0);
        space_used   = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
        pop_eligible = (state == RUN) & have_work & (space_used < 3'd2);
        bus.stk_pop  = pop_eligible & ~bus.stk_empty;
        pop_acc      = bus.stk_pop & ~push_wins;
    end

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = fifo_mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            occ         <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight <= pop_acc;
            case ({inflight, deq})
                2'b10: begin
                    fifo_mem[occ[0]] <= bus.stk_d_out;
                    occ              <= occ + 2'd1;
                end
                2'b01: begin
                    fifo_mem[0] <= fifo_mem[1];
                    occ         <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        fifo_mem[0] <= fifo_mem[1];
                        fifo_mem[1] <= bus.stk_d_out;
                    end else begin
                        fifo_mem[0] <= bus.stk_d_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // cmd_ready is its own register so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.cmd_ready  <= 1'b0;
            remaining      <= '0;
            popped         <= '0;
            drain_mode     <= 1'b0;
            short_flag     <= 1'b0;
            bus.done       <= 1'b0;
            bus.done_count <= '0;
            bus.done_short <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (pop_acc) begin
                popped <= popped + ONE;
                if (!drain_mode) begin
                    remaining <= remaining - ONE;
                end
            end
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        state         <= RUN;
                        bus.cmd_ready <= 1'b0;
                        remaining     <= bus.cmd_count;
                        popped        <= '0;
                        drain_mode    <= (bus.cmd_count == '0);
                        short_flag    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!drain_mode && remaining == '0) begin
                        state <= FLUSH;
                    end else if (pop_eligible && bus.stk_empty) begin
                        state      <= FLUSH;
                        short_flag <= ~drain_mode;
                    end
                end
                FLUSH: begin
                    if (!inflight && occ == 2'd0) begin
                        state          <= DONE;
                        bus.done       <= 1'b1;
                        bus.done_count <= popped;
                        bus.done_short <= short_flag;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
